freq_div_2: RTL and testbench

FREQ_DIV_2 -- requirements
Module: freq_div_2

---
 rtl/freq_div_2.sv | 71 +++++++
 tb/tb_freq_div_2.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/freq_div_2.sv
// Integer clock divider with 50% duty output for both even and odd ratios.
// Odd ratios stretch the high phase by half a clk period using a falling-edge copy register.
module freq_div_2 #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic freq_out
);

  localparam int CNT_W = $clog2(DIV);

  generate
    if (DIV < 2 || DIV > 1024) begin : g_bad_div
      $error("freq_div_2: DIV=%0d is outside the legal range 2..1024", DIV);
    end
  endgenerate

  logic [CNT_W-1:0] cnt;

  // Phase counter: 0..DIV-1, restarts from 0 whenever reset is applied.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  generate
    if (DIV % 2 == 0) begin : g_even
      logic out_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          out_q <= 1'b0;
        end else if (cnt == CNT_W'(DIV / 2 - 1) || cnt == CNT_W'(DIV - 1)) begin
          out_q <= ~out_q;
        end
      end

      assign freq_out = out_q;
    end else begin : g_odd
      logic p_q;
      logic n_q;

      // p_q is high while the registered count sits in the upper half (DIV-1)/2+1..DIV-1,
      // so it is loaded from the count value one step earlier.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          p_q <= 1'b0;
        end else begin
          p_q <= (cnt >= CNT_W'((DIV - 1) / 2)) && (cnt != CNT_W'(DIV - 1));
        end
      end

      always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
          n_q <= 1'b0;
        end else begin
          n_q <= p_q;
        end
      end

      assign freq_out = p_q | n_q;
    end
  endgenerate

endmodule

// File: tb/tb_freq_div_2.sv
// Randomized reset/run bench for freq_div_2 across several ratios, checked against
// a half-cycle timeline model through an expectation queue.
module tb_freq_div_2;

  localparam int NUM_DUT = 5;

  function automatic int div_of(input int idx);
    case (idx)
      0:       return 2;
      1:       return 3;
      2:       return 4;
      3:       return 5;
      default: return 8;
    endcase
  endfunction

  bit clk;
  logic rst;
  logic [NUM_DUT-1:0] fo;

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < NUM_DUT; gi++) begin : g_dut
      freq_div_2 #(.DIV(div_of(gi))) u_dut (
        .clk      (clk),
        .rst      (rst),
        .freq_out (fo[gi])
      );
    end
  endgenerate

  // Timeline state: rising edges seen since release and whether a falling edge followed the last one.
  int k_rise;
  int f_fall;
  bit in_reset;

  int total;
  int bad;

  logic [NUM_DUT-1:0] exp_q[$];
  event sample_ev;

  // Output expressed in half-cycles t since release: low until the first-high point s,
  // then high for DIV half-cycles out of every 2*DIV.
  function automatic logic model_out(input int div, input int kk, input int ff, input bit rst_active);
    int t;
    int s;
    if (rst_active) return 1'b0;
    t = 2 * kk + ff;
    s = (div % 2 == 0) ? div : div + 1;
    if (t < s) return 1'b0;
    return ((t - s) % (2 * div)) < div;
  endfunction

  task automatic push_expect();
    logic [NUM_DUT-1:0] e;
    for (int i = 0; i < NUM_DUT; i++) e[i] = model_out(div_of(i), k_rise, f_fall, in_reset);
    exp_q.push_back(e);
  endtask

  task automatic half_step();
    @(clk);
    #1;
    if (!in_reset) begin
      if (clk) begin
        k_rise++;
        f_fall = 0;
      end else if (k_rise > 0) begin
        f_fall = 1;
      end
    end
    push_expect();
    #1 -> sample_ev;
  endtask

  task automatic assert_reset();
    #1 rst = 1'b0;
    in_reset = 1'b1;
    k_rise = 0;
    f_fall = 0;
    #1;
    push_expect();
    -> sample_ev;
  endtask

  task automatic release_reset();
    #1 rst = 1'b1;
    in_reset = 1'b0;
    k_rise = 0;
    f_fall = 0;
  endtask

  initial begin : monitor
    logic [NUM_DUT-1:0] e;
    forever begin
      @(sample_ev);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL queue_empty at %0t: got freq_out=%b, no expectation queued", $time, fo);
      end else begin
        e = exp_q.pop_front();
        for (int i = 0; i < NUM_DUT; i++) begin
          total++;
          if (fo[i] !== e[i]) begin
            bad++;
            $display("FAIL freq_out_div%0d at %0t: got %b, expected %b", div_of(i), $time, fo[i], e[i]);
          end
        end
      end
    end
  end

  initial begin : stimulus
    int run_len;
    int hold_len;
    rst = 1'b0;
    in_reset = 1'b1;
    k_rise = 0;
    f_fall = 0;
    total = 0;
    bad = 0;

    // Reset held low across several clk edges.
    #1;
    push_expect();
    -> sample_ev;
    repeat (4) half_step();
    $display("seg init: reset held for 4 half-cycles");

    for (int seg = 0; seg < 12; seg++) begin
      release_reset();
      run_len = $urandom_range(20, 90);
      repeat (run_len) half_step();
      assert_reset();
      hold_len = $urandom_range(1, 4);
      repeat (hold_len) half_step();
      $display("seg %0d: run_half_cycles=%0d reset_hold_half_cycles=%0d", seg, run_len, hold_len);
    end

    // Long final run to cover several full periods of every ratio.
    release_reset();
    repeat (200) half_step();
    $display("seg final: run_half_cycles=200");

    #3;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
